// File: rtl/axi_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_ram
// Purpose  : AXI4 slave memory with independent read and write burst
//            engines. Byte addressed, one data word per beat, byte-strobe
//            writes. Memory contents are not cleared by reset.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   s_axi_aw*           : write address channel (lock/cache/prot ignored)
//   s_axi_w*            : write data channel (wlast ignored, awlen rules)
//   s_axi_b*            : write response channel (bresp always OKAY)
//   s_axi_ar*           : read address channel (lock/cache/prot ignored)
//   s_axi_r*            : read data channel (rresp always OKAY)
// Parameters
//   DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH, ID_WIDTH
//   PIPELINE_OUTPUT     : 1 adds one register stage on the R channel
// ============================================================================
module axi_burst_ram #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 8,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  // write address
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int ADDR_LSB  = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH = ADDR_WIDTH - ADDR_LSB;
  localparam int WORDS     = 2 ** IDX_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;

  // Next beat address: FIXED stays put, INCR and WRAP both step by 2^size.
  // The sum is truncated to ADDR_WIDTH, so the address wraps at the top.
  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    if (burst == BURST_FIXED) return addr;
    return addr + (ADDR_WIDTH'(1) << size);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  // Sideband inputs with no effect on this memory model.
  logic w_unused_inputs;
  assign w_unused_inputs = &{1'b0, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                             s_axi_arlock, s_axi_arcache, s_axi_arprot,
                             s_axi_wlast};

  // --------------------------------------------------------------------------
  // Write engine
  // --------------------------------------------------------------------------
  logic [0:0]            r_wstate;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wcnt;
  logic [2:0]            r_wsize;
  logic [1:0]            r_wburst;
  logic [ID_WIDTH-1:0]   r_wid;
  logic [ID_WIDTH-1:0]   r_bid;
  logic                  r_bvalid;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic [IDX_WIDTH-1:0]  w_widx;

  // A new write may start while the previous response is being accepted.
  assign s_axi_awready = !rst && (r_wstate == ST_IDLE) && (!r_bvalid || s_axi_bready);
  assign s_axi_wready  = !rst && (r_wstate == ST_BURST);
  assign w_aw_hs       = s_axi_awvalid && s_axi_awready;
  assign w_w_hs        = s_axi_wvalid && s_axi_wready;
  assign w_widx        = r_waddr[ADDR_WIDTH-1:ADDR_LSB];

  assign s_axi_bid    = r_bid;
  assign s_axi_bresp  = 2'b00;
  assign s_axi_bvalid = r_bvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate <= ST_IDLE;
      r_bvalid <= 1'b0;
      r_bid    <= '0;
    end else begin
      if (r_bvalid && s_axi_bready) r_bvalid <= 1'b0;
      case (r_wstate)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_wid    <= s_axi_awid;
            r_waddr  <= s_axi_awaddr;
            r_wcnt   <= s_axi_awlen;
            r_wsize  <= s_axi_awsize;
            r_wburst <= s_axi_awburst;
            r_wstate <= ST_BURST;
          end
        end
        default: begin
          if (w_w_hs) begin
            r_waddr <= f_next_addr(r_waddr, r_wsize, r_wburst);
            if (r_wcnt == 8'd0) begin
              r_bvalid <= 1'b1;
              r_bid    <= r_wid;
              r_wstate <= ST_IDLE;
            end else begin
              r_wcnt <= r_wcnt - 8'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) r_mem[w_widx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read engine
  // --------------------------------------------------------------------------
  logic [0:0]            r_rstate;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rcnt;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic [ID_WIDTH-1:0]   r_rid_cap;
  logic [IDX_WIDTH-1:0]  w_ridx;
  logic                  w_ar_hs;
  // First output register stage
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ID_WIDTH-1:0]   r_rid;
  logic                  r_rlast;
  logic                  r_rvalid;
  // Stage one is drained this cycle (by the master or by the pipe stage)
  logic                  w_r1_ready;

  assign s_axi_arready = !rst && (r_rstate == ST_IDLE);
  assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
  assign w_ridx        = r_raddr[ADDR_WIDTH-1:ADDR_LSB];
  assign s_axi_rresp   = 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= ST_IDLE;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
    end else begin
      if (r_rvalid && w_r1_ready) r_rvalid <= 1'b0;
      case (r_rstate)
        ST_IDLE: begin
          if (w_ar_hs) begin
            r_rid_cap <= s_axi_arid;
            r_raddr   <= s_axi_araddr;
            r_rcnt    <= s_axi_arlen;
            r_rsize   <= s_axi_arsize;
            r_rburst  <= s_axi_arburst;
            r_rstate  <= ST_BURST;
          end
        end
        default: begin
          // Refill only when the held beat is absent or leaving, so a
          // stalled beat keeps its data, id and last flag.
          if (!r_rvalid || w_r1_ready) begin
            r_rdata  <= r_mem[w_ridx];
            r_rid    <= r_rid_cap;
            r_rlast  <= (r_rcnt == 8'd0);
            r_rvalid <= 1'b1;
            r_raddr  <= f_next_addr(r_raddr, r_rsize, r_rburst);
            if (r_rcnt == 8'd0) r_rstate <= ST_IDLE;
            else                r_rcnt   <= r_rcnt - 8'd1;
          end
        end
      endcase
    end
  end

  generate
    if (PIPELINE_OUTPUT != 0) begin : g_pipe
      logic [DATA_WIDTH-1:0] r_p_rdata;
      logic [ID_WIDTH-1:0]   r_p_rid;
      logic                  r_p_rlast;
      logic                  r_p_rvalid;

      assign w_r1_ready = !r_p_rvalid || s_axi_rready;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_p_rvalid <= 1'b0;
          r_p_rlast  <= 1'b0;
          r_p_rid    <= '0;
          r_p_rdata  <= '0;
        end else begin
          if (r_p_rvalid && s_axi_rready) r_p_rvalid <= 1'b0;
          if (r_rvalid && w_r1_ready) begin
            r_p_rvalid <= 1'b1;
            r_p_rdata  <= r_rdata;
            r_p_rid    <= r_rid;
            r_p_rlast  <= r_rlast;
          end
        end
      end

      assign s_axi_rdata  = r_p_rdata;
      assign s_axi_rid    = r_p_rid;
      assign s_axi_rlast  = r_p_rlast;
      assign s_axi_rvalid = r_p_rvalid;
    end else begin : g_direct
      assign w_r1_ready   = s_axi_rready;
      assign s_axi_rdata  = r_rdata;
      assign s_axi_rid    = r_rid;
      assign s_axi_rlast  = r_rlast;
      assign s_axi_rvalid = r_rvalid;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_burst_ram
// Purpose  : Directed self-checking bench for axi_burst_ram (64-bit data,
//            16-bit address, no R pipeline stage).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_burst_ram;

  localparam int DW  = 64;
  localparam int AW  = 16;
  localparam int SW  = DW / 8;
  localparam int IDW = 8;

  localparam logic [1:0] BT_FIXED = 2'b00;
  localparam logic [1:0] BT_INCR  = 2'b01;

  logic           clk = 1'b0;
  logic           rst;
  logic [IDW-1:0] awid;
  logic [AW-1:0]  awaddr;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;
  logic           awvalid, awready;
  logic [DW-1:0]  wdata;
  logic [SW-1:0]  wstrb;
  logic           wlast, wvalid, wready;
  logic [IDW-1:0] bid;
  logic [1:0]     bresp;
  logic           bvalid, bready;
  logic [IDW-1:0] arid;
  logic [AW-1:0]  araddr;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;
  logic           arvalid, arready;
  logic [IDW-1:0] rid;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast, rvalid, rready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] wbuf [16];
  logic [DW-1:0] rbuf [16];
  logic [15:0]   rlast_mask;
  logic [IDW-1:0] rid_seen;
  int            nbeats;
  int            lat;
  logic [IDW-1:0] b_id;
  logic [1:0]    b_resp;

  axi_burst_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IDW),
    .PIPELINE_OUTPUT(0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(1'b0),
    .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [IDW-1:0] id);
    logic hs;
    logic got = 1'b0;
    awaddr = addr; awlen = len; awburst = burst; awid = id; awsize = 3'd3;
    awvalid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      hs = awready;
      @(posedge clk); #1;
      if (hs) begin got = 1'b1; break; end
    end
    awvalid = 1'b0;
    check("aw_handshake", 64'(got), 64'd1);
  endtask

  task automatic w_send(input int beats, input logic [SW-1:0] strb);
    logic hs;
    logic ok = 1'b1;
    for (int i = 0; i < beats; i++) begin
      logic got = 1'b0;
      wdata = wbuf[i]; wstrb = strb; wlast = (i == beats - 1); wvalid = 1'b1;
      for (int t = 0; t < 64; t++) begin
        hs = wready;
        @(posedge clk); #1;
        if (hs) begin got = 1'b1; break; end
      end
      if (!got) ok = 1'b0;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("w_handshake", 64'(ok), 64'd1);
  endtask

  task automatic b_recv(output logic [IDW-1:0] id_o, output logic [1:0] resp_o);
    logic hs;
    logic got = 1'b0;
    id_o = '1; resp_o = 2'b11;
    bready = 1'b1;
    for (int t = 0; t < 64; t++) begin
      hs = bvalid; id_o = bid; resp_o = bresp;
      @(posedge clk); #1;
      if (hs) begin got = 1'b1; break; end
    end
    bready = 1'b0;
    check("b_handshake", 64'(got), 64'd1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [IDW-1:0] id,
                          input logic [SW-1:0] strb);
    aw_send(addr, len, burst, id);
    w_send(int'(len) + 1, strb);
    b_recv(b_id, b_resp);
  endtask

  // Collects one read burst into rbuf/rlast_mask. With bp set, rready is
  // dropped every other cycle and stalled beats are checked for stability.
  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [IDW-1:0] id,
                         input bit bp);
    logic hs;
    logic got = 1'b0;
    logic hold = 1'b0;
    logic extra = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic held_last = 1'b0;
    int hs_cyc = 0;
    int first_cyc = -1;
    nbeats = 0; rlast_mask = '0; rid_seen = '0;
    araddr = addr; arlen = len; arburst = burst; arid = id; arsize = 3'd3;
    arvalid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      hs = arready;
      @(posedge clk); #1;
      if (hs) begin got = 1'b1; break; end
    end
    arvalid = 1'b0;
    hs_cyc = cyc;
    check("ar_handshake", 64'(got), 64'd1);
    for (int k = 0; k < 200; k++) begin
      rready = bp ? (k % 2 == 0) : 1'b1;
      if (hold) begin
        check("r_hold_data", rdata, held_data);
        check("r_hold_last", 64'({rvalid, rlast}), 64'({1'b1, held_last}));
      end
      hold = rvalid && !rready;
      held_data = rdata; held_last = rlast;
      if (rvalid && first_cyc < 0) first_cyc = cyc;
      hs = rvalid && rready;
      if (hs && nbeats < 16) begin
        rbuf[nbeats] = rdata;
        rlast_mask[nbeats] = rlast;
        rid_seen = rid;
        nbeats++;
      end
      @(posedge clk); #1;
      if (nbeats == int'(len) + 1) break;
    end
    rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      extra = extra | rvalid;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    check("r_no_extra_beats", 64'(extra), 64'd0);
    lat = first_cyc - hs_cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stuck;
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;

    // Reset: handshake outputs low throughout, readys up right after release.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_outputs", 64'({awready, wready, bvalid, arready, rvalid, rlast}), 64'd0);
    end
    check("rst_ids_data", 64'({bid, rid}), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'({awready, arready}), 64'b11);

    // Single beat write then read; first rvalid one edge after the AR edge
    // (i.e. AR handshake cycle N, rvalid in cycle N+2).
    wbuf[0] = 64'h1122334455667788;
    do_write(16'h0100, 8'd0, BT_INCR, 8'd5, 8'hFF);
    check("single_bid", 64'(b_id), 64'd5);
    check("single_bresp", 64'(b_resp), 64'd0);
    do_read(16'h0100, 8'd0, BT_INCR, 8'd7, 1'b0);
    check("single_rdata", rbuf[0], 64'h1122334455667788);
    check("single_rid", 64'(rid_seen), 64'd7);
    check("single_rlast", 64'(rlast_mask), 64'h1);
    check("single_latency", 64'(lat), 64'd1);

    // INCR burst of four beats, one B response only.
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i);
    do_write(16'h0040, 8'd3, BT_INCR, 8'd3, 8'hFF);
    check("incr_bid", 64'(b_id), 64'd3);
    repeat (3) @(posedge clk);
    #1;
    check("incr_single_b", 64'(bvalid), 64'd0);
    do_read(16'h0040, 8'd3, BT_INCR, 8'd4, 1'b0);
    check("incr_beats", 64'(nbeats), 64'd4);
    for (int i = 0; i < 4; i++) check("incr_rdata", rbuf[i], 64'(i));
    check("incr_rlast", 64'(rlast_mask), 64'h8);

    // Byte strobes: clear only the low four bytes.
    wbuf[0] = 64'hFFFFFFFFFFFFFFFF;
    do_write(16'h0080, 8'd0, BT_INCR, 8'd1, 8'hFF);
    wbuf[0] = 64'h0;
    do_write(16'h0080, 8'd0, BT_INCR, 8'd1, 8'h0F);
    do_read(16'h0080, 8'd0, BT_INCR, 8'd1, 1'b0);
    check("strobe_rdata", rbuf[0], 64'hFFFFFFFF00000000);

    // FIXED burst: all beats land on 0x8, neighbour 0x10 keeps its value.
    wbuf[0] = 64'h0123456789ABCDEF;
    do_write(16'h0010, 8'd0, BT_INCR, 8'd2, 8'hFF);
    wbuf[0] = 64'hAAAAAAAAAAAAAAAA;
    wbuf[1] = 64'hBBBBBBBBBBBBBBBB;
    wbuf[2] = 64'hCCCCCCCCCCCCCCCC;
    do_write(16'h0008, 8'd2, BT_FIXED, 8'd2, 8'hFF);
    do_read(16'h0008, 8'd0, BT_INCR, 8'd2, 1'b0);
    check("fixed_rdata", rbuf[0], 64'hCCCCCCCCCCCCCCCC);
    do_read(16'h0010, 8'd0, BT_INCR, 8'd2, 1'b0);
    check("fixed_neighbour", rbuf[0], 64'h0123456789ABCDEF);

    // Read backpressure on an eight-beat burst.
    for (int i = 0; i < 8; i++) wbuf[i] = 64'h1000 + 64'(i * 3);
    do_write(16'h0200, 8'd7, BT_INCR, 8'd6, 8'hFF);
    do_read(16'h0200, 8'd7, BT_INCR, 8'd8, 1'b1);
    check("bp_beats", 64'(nbeats), 64'd8);
    for (int i = 0; i < 8; i++) check("bp_rdata", rbuf[i], 64'h1000 + 64'(i * 3));
    check("bp_rlast", 64'(rlast_mask), 64'h80);
    check("bp_rid", 64'(rid_seen), 64'd8);

    // Pending B response blocks AW until bready.
    aw_send(16'h0300, 8'd0, BT_INCR, 8'd9);
    wbuf[0] = 64'h5555;
    w_send(1, 8'hFF);
    stuck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stuck = stuck | awready;
      @(posedge clk); #1;
    end
    check("awready_blocked", 64'(stuck), 64'd0);
    check("bvalid_held", 64'(bvalid), 64'd1);
    bready = 1'b1;
    #1;
    check("awready_on_bready", 64'(awready), 64'd1);
    b_recv(b_id, b_resp);
    check("blocked_bid", 64'(b_id), 64'd9);

    // Address wrap past 0xFFFF: the second beat lands at 0x0000.
    wbuf[0] = 64'h7777777777777777;
    wbuf[1] = 64'h8888888888888888;
    do_write(16'hFFF8, 8'd1, BT_INCR, 8'd10, 8'hFF);
    do_read(16'h0000, 8'd0, BT_INCR, 8'd11, 1'b0);
    check("wrap_low_word", rbuf[0], 64'h8888888888888888);
    do_read(16'hFFF8, 8'd1, BT_INCR, 8'd12, 1'b0);
    check("wrap_read_beat0", rbuf[0], 64'h7777777777777777);
    check("wrap_read_beat1", rbuf[1], 64'h8888888888888888);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_burst_ram.md
Name: axi_burst_ram

Overview:
- AXI4 full-protocol slave memory with independent read and write burst engines.
- Serves as the external-memory model that the Rasterix SRAM rasterizer masters for framebuffer and texture storage in the simulation top level.
- Byte-addressed, one data word per beat, byte-strobe writes; memory contents are not reset.

Parameters:
DATA_WIDTH, 32, data bus width in bits; top level uses 64.
ADDR_WIDTH, 16, byte address width; top level uses 25.
STRB_WIDTH, DATA_WIDTH/8, write strobe width; DATA_WIDTH must be a multiple of 8.
ID_WIDTH, 8, transaction ID width.
PIPELINE_OUTPUT, 0, 1 adds one register stage on the R channel.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  reset; synchronous, active-high.
s_axi_awid  in  ID_WIDTH  write ID, captured on AW handshake.
s_axi_awaddr  in  ADDR_WIDTH  write start byte address.
s_axi_awlen  in  8  beats minus one.
s_axi_awsize  in  3  log2 bytes per beat.
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP (handled as INCR).
s_axi_awlock/awcache/awprot  in  1/4/3  ignored (three ports).
s_axi_awvalid, s_axi_awready  in, out  1  AW handshake.
s_axi_wdata  in  DATA_WIDTH  write data.
s_axi_wstrb  in  STRB_WIDTH  byte enables.
s_axi_wlast  in  1  ignored; burst length comes from awlen.
s_axi_wvalid, s_axi_wready  in, out  1  W handshake.
s_axi_bid  out  ID_WIDTH  equals captured awid.
s_axi_bresp  out  2  constant 00 (OKAY).
s_axi_bvalid, s_axi_bready  out, in  1  B handshake.
s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst  in  as AW counterparts  read command.
s_axi_arlock/arcache/arprot  in  1/4/3  ignored (three ports).
s_axi_arvalid, s_axi_arready  in, out  1  AR handshake.
s_axi_rid  out  ID_WIDTH  equals captured arid.
s_axi_rdata  out  DATA_WIDTH  read data.
s_axi_rresp  out  2  constant 00.
s_axi_rlast  out  1  high on the final beat.
s_axi_rvalid, s_axi_rready  out, in  1  R handshake.

Behaviour:
- Storage: 2^(ADDR_WIDTH-log2(STRB_WIDTH)) words; word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]; low address bits are ignored.
- Reset: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, rid, rdata = 0; both FSMs go to IDLE; memory is untouched.
- Write FSM, IDLE:
  - awready = 1 when bvalid=0, or when bready=1 in the same cycle.
  - On AW handshake: capture id, addr, len (beat counter), size, burst; go to BURST.
- Write FSM, BURST:
  - wready = 1.
  - On each W handshake, write bytes i where wstrb[i]=1 to mem[index].
  - Address advances by 2^size bytes unless burst=FIXED.
  - If counter=0, drop wready, set bvalid=1 and bid next cycle, go to IDLE; otherwise decrement the counter.
- B channel: bvalid is held until bready; clears on handshake.
- Read FSM, IDLE:
  - arready = 1.
  - On AR handshake: capture id, addr, len, size, burst; go to BURST.
- Read FSM, BURST:
  - Whenever the R output register is empty or consumed this cycle (rvalid=0 or rready=1), read mem[index] into rdata.
  - Set rvalid=1, rid, and rlast=(counter==0); advance the address per burst type.
  - On the last beat, return to IDLE.
- Read latency: AR handshake in cycle N gives first rvalid in cycle N+2, plus 1 if PIPELINE_OUTPUT=1.
- R throughput: one beat per cycle while rready=1.
- rvalid=1 with rready=0 holds rdata, rid and rlast stable.
- Read and write engines are fully concurrent.
- Read and write to the same word in the same cycle: the read returns the old data.
- Address wrap-around past the top of the address space wraps modulo 2^ADDR_WIDTH.
- Reset asserted mid-burst aborts both bursts; no B or R response follows.

Test Plan:
- Reset: hold rst for 3 cycles -> all valid/ready outputs are 0 during reset; awready=1 and arready=1 in the first cycle after release.
- Single write/read (DATA_WIDTH=64): AW addr 0x100, len 0, id 5, W 0x1122334455667788, strb 0xFF -> bvalid with bid=5, bresp=0. Then AR 0x100, id 7 -> rdata 0x1122334455667788, rid=7, rlast=1, rvalid at AR+2.
- INCR burst: write len 3 at 0x40, data 0,1,2,3 -> a single B response. Read len 3 at 0x40 -> beats 0,1,2,3, rlast only on the 4th.
- Strobes: write all-ones to 0x80, then write 0 with strb 0x0F -> read returns 0xFFFFFFFF00000000.
- FIXED burst: len 2 at 0x8 with data A,B,C -> read of 0x8 returns C; 0x10 is unchanged.
- Backpressure: toggle rready 1/0 during a len-7 read -> exactly 8 beats, none lost or duplicated. Hold bready=0 after a write -> awready stays 0 until the B handshake.
